// File: rtl/gmsk_burst_serializer.sv
// ----------------------------------------------------------------------------
// gmsk_burst_serializer
//
// Upstream feeder for the GMSK I/Q modulator. Turns a byte stream into one GSM
// normal burst of symbols (head tail, payload, end tail, guard) and presents
// them on current_symbol, advancing on the modulator's symbol strobe.
//
// Optional feature macro: GMSK_DIFF_ENCODE_EN
//   defined   : current_symbol = b[i] ^ b[i-1], with b[-1] = 1 at burst start
//   undefined : current_symbol = b[i]
//
// Ports
//   clock              in   system clock
//   reset_n            in   asynchronous active-low reset
//   burst_start        in   one-cycle burst request, honoured only in IDLE
//   byte_in[7:0]       in   payload byte, bit 7 sent first
//   byte_valid         in   byte_in valid
//   byte_ready         out  byte accepted this cycle when byte_valid is high
//   sample_strobe      in   modulator sample strobe
//   next_symbol_strobe in   modulator symbol strobe (advance = both strobes high)
//   current_symbol     out  symbol taken by the modulator at the next advance
//   burst_active       out  high while a burst is in progress
//   burst_done         out  one-cycle pulse after the last guard symbol
//   underflow          out  one-cycle pulse when a payload byte was missing
// ----------------------------------------------------------------------------
module gmsk_burst_serializer #(
    parameter int unsigned TAIL_BITS    = 3,
    parameter int unsigned PAYLOAD_BITS = 142,
    parameter int unsigned GUARD_BITS   = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       burst_start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       sample_strobe,
    input  logic       next_symbol_strobe,
    output logic       current_symbol,
    output logic       burst_active,
    output logic       burst_done,
    output logic       underflow
);

    localparam int unsigned NUM_BYTES = (PAYLOAD_BITS + 7) / 8;
    localparam int unsigned MAX_TG    = (TAIL_BITS > GUARD_BITS) ? TAIL_BITS : GUARD_BITS;
    localparam int unsigned MAX_LEN   = (PAYLOAD_BITS > MAX_TG) ? PAYLOAD_BITS : MAX_TG;
    localparam int unsigned CNT_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned SLOT_W    = $clog2(NUM_BYTES + 1);

    localparam logic [CNT_W-1:0] TAIL_LAST    = CNT_W'(TAIL_BITS - 1);
    localparam logic [CNT_W-1:0] PAYLOAD_LAST = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_BITS - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HEAD    = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_TAIL    = 3'd3;
    localparam logic [2:0] ST_GUARD   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic              cur_sym_q, cur_sym_d;
    logic [7:0]        sr_q, sr_d;
    logic [3:0]        sr_cnt_q, sr_cnt_d;      // bits still unsent in sr_q
    logic [7:0]        hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;  // payload byte slots already started
    logic              done_q, done_d;
    logic              underflow_q, underflow_d;

`ifdef GMSK_DIFF_ENCODE_EN
    // Raw bit of the symbol currently presented; the start-of-burst reference of 1 is
    // injected directly when the first head symbol is loaded.
    logic              prev_b_q, prev_b_d;
`endif

    logic       advance;
    logic       byte_xfer;
    logic       load_sym;
    logic       next_b;
    logic       take_pay;
    logic       start_burst;
    logic       pay_b;
    logic       pay_new_slot;
    logic [7:0] pay_sr;
    logic [3:0] pay_cnt;

    assign advance      = sample_strobe & next_symbol_strobe;
    assign burst_active = (state_q != ST_IDLE);
    assign byte_ready   = ((state_q == ST_HEAD) || (state_q == ST_PAYLOAD)) && !hold_valid_q &&
                          (slot_cnt_q < SLOT_W'(NUM_BYTES));
    assign byte_xfer    = byte_valid & byte_ready;

    assign current_symbol = cur_sym_q;
    assign burst_done     = done_q;
    assign underflow      = underflow_q;

    // Next payload bit: from the shift register, or from a fresh slot (holding byte, or
    // zeros when the holding buffer is empty).
    always_comb begin
        pay_new_slot = (sr_cnt_q == 4'd0);
        if (pay_new_slot) begin
            pay_b   = hold_valid_q & hold_q[7];
            pay_sr  = hold_valid_q ? {hold_q[6:0], 1'b0} : 8'd0;
            pay_cnt = 4'd7;
        end else begin
            pay_b   = sr_q[7];
            pay_sr  = {sr_q[6:0], 1'b0};
            pay_cnt = sr_cnt_q - 4'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        sym_cnt_d    = sym_cnt_q;
        cur_sym_d    = cur_sym_q;
        sr_d         = sr_q;
        sr_cnt_d     = sr_cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        slot_cnt_d   = slot_cnt_q;
        done_d       = 1'b0;
        underflow_d  = 1'b0;
        load_sym     = 1'b0;
        next_b       = 1'b0;
        take_pay     = 1'b0;
        start_burst  = 1'b0;
`ifdef GMSK_DIFF_ENCODE_EN
        prev_b_d     = prev_b_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (burst_start) begin
                    state_d      = ST_HEAD;
                    sym_cnt_d    = '0;
                    load_sym     = 1'b1;
                    start_burst  = 1'b1;
                    sr_cnt_d     = 4'd0;
                    hold_valid_d = 1'b0;
                    slot_cnt_d   = '0;
                end
            end
            ST_HEAD: begin
                if (advance) begin
                    load_sym = 1'b1;
                    if (sym_cnt_q == TAIL_LAST) begin
                        state_d   = ST_PAYLOAD;
                        sym_cnt_d = '0;
                        take_pay  = 1'b1;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (advance) begin
                    load_sym = 1'b1;
                    if (sym_cnt_q == PAYLOAD_LAST) begin
                        state_d   = ST_TAIL;
                        sym_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                        take_pay  = 1'b1;
                    end
                end
            end
            ST_TAIL: begin
                if (advance) begin
                    load_sym = 1'b1;
                    if (sym_cnt_q == TAIL_LAST) begin
                        state_d   = ST_GUARD;
                        sym_cnt_d = '0;
                        next_b    = 1'b1;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end
            end
            ST_GUARD: begin
                if (advance) begin
                    if (sym_cnt_q == GUARD_LAST) begin
                        state_d   = ST_IDLE;
                        sym_cnt_d = '0;
                        done_d    = 1'b1;
                        cur_sym_d = 1'b0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                        load_sym  = 1'b1;
                        next_b    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_pay) begin
            next_b   = pay_b;
            sr_d     = pay_sr;
            sr_cnt_d = pay_cnt;
            if (pay_new_slot) begin
                // A missing byte still consumes its slot so the burst keeps its length.
                slot_cnt_d   = slot_cnt_q + 1'b1;
                hold_valid_d = 1'b0;
                underflow_d  = ~hold_valid_q;
            end
        end

        // byte_ready excludes a full holding buffer, so this never collides with a move-out.
        if (byte_xfer) begin
            hold_d       = byte_in;
            hold_valid_d = 1'b1;
        end

        if (load_sym) begin
`ifdef GMSK_DIFF_ENCODE_EN
            cur_sym_d = next_b ^ (start_burst ? 1'b1 : prev_b_q);
            prev_b_d  = next_b;
`else
            cur_sym_d = next_b;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sym_cnt_q    <= '0;
            cur_sym_q    <= 1'b0;
            sr_q         <= 8'd0;
            sr_cnt_q     <= 4'd0;
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
            slot_cnt_q   <= '0;
            done_q       <= 1'b0;
            underflow_q  <= 1'b0;
`ifdef GMSK_DIFF_ENCODE_EN
            prev_b_q     <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            cur_sym_q    <= cur_sym_d;
            sr_q         <= sr_d;
            sr_cnt_q     <= sr_cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            slot_cnt_q   <= slot_cnt_d;
            done_q       <= done_d;
            underflow_q  <= underflow_d;
`ifdef GMSK_DIFF_ENCODE_EN
            prev_b_q     <= prev_b_d;
`endif
        end
    end

endmodule
